// File: rtl/mips_boot_loader_if.sv
// ---------------------------------------------------------------------------
// mips_boot_loader_if
//   Bundles the host-side stream, session control, memory write port and
//   status signals of the MIPS boot loader.
//   Modports:
//     master : host/bench side. Drives start/sel/base_addr/word_count and the
//              stream, observes in_ready, the memory write port and status.
//     slave  : loader side (mips_boot_loader).
//   Signals:
//     start, sel, base_addr, word_count : session control (latched on start)
//     in_valid, in_data, in_ready       : 32-bit big-endian word stream
//     mem_we, mem_addr, mem_wdata       : one-hot byte write port to memories
//     busy, done, cpu_run, err          : session status and core release
//     checksum                          : only with BOOT_LOADER_CHECKSUM_EN
// ---------------------------------------------------------------------------
interface mips_boot_loader_if #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int NUM_MEM = 2
);
  localparam int SEL_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;

  logic               start;
  logic [SEL_W-1:0]   sel;
  logic [ADDR_W-1:0]  base_addr;
  logic [ADDR_W-1:0]  word_count;
  logic               in_valid;
  logic [WORD_W-1:0]  in_data;
  logic               in_ready;
  logic [NUM_MEM-1:0] mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_wdata;
  logic               busy;
  logic               done;
  logic               cpu_run;
  logic               err;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]  checksum;
`endif

  modport master (
`ifdef BOOT_LOADER_CHECKSUM_EN
    input  checksum,
`endif
    output start, sel, base_addr, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_run, err
  );

  modport slave (
`ifdef BOOT_LOADER_CHECKSUM_EN
    output checksum,
`endif
    input  start, sel, base_addr, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_run, err
  );
endinterface

// File: rtl/mips_boot_loader.sv
// ---------------------------------------------------------------------------
// mips_boot_loader
//   Loads the byte-wide big-endian instruction/data memories of the MIPS core
//   from a valid/ready word stream, then releases the core through cpu_run.
//   Each accepted word is written as BYTES consecutive byte writes, MSB first.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : mips_boot_loader_if.slave (control, stream, memory port, status)
//   Configuration:
//     BOOT_LOADER_CHECKSUM_EN : when defined, adds bus.checksum, the modulo
//                               2^WORD_W sum of the words accepted this session.
// ---------------------------------------------------------------------------
module mips_boot_loader #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int NUM_MEM = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_boot_loader_if.slave  bus
);
  localparam int BYTES  = WORD_W / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SPLIT, FIN} state_t;

  state_t              state, state_next;
  logic [NUM_MEM-1:0]  we_mask;     // one-hot target, all zero for a bad sel
  logic [ADDR_W-1:0]   addr;        // address of the next byte write
  logic [ADDR_W-1:0]   words_left;
  logic [WORD_W-1:0]   word;        // remaining bytes, next one at the top
  logic [BCNT_W-1:0]   byte_idx;    // byte currently on the write port
  logic                wrapped;     // address counter has carried this session
  logic [NUM_MEM-1:0]  mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_wdata;
  logic                cpu_run;
  logic                err;

  logic                take_start, take_word, last_byte, emit;
  logic [7:0]          emit_byte;
  logic [ADDR_W-1:0]   addr_inc;
  logic                addr_carry;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    take_start = 1'b0;
    take_word  = 1'b0;
    last_byte  = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin
               take_start = 1'b1;
               state_next = WAIT;
             end
      WAIT:  if (words_left == '0) begin
               state_next = FIN;
             end else if (bus.in_valid) begin
               take_word  = 1'b1;
               state_next = SPLIT;
             end
      SPLIT: if (byte_idx == BCNT_W'(BYTES - 1)) begin
               last_byte  = 1'b1;
               state_next = (words_left == '0) ? FIN : WAIT;
             end
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Byte 0 is issued on the acceptance edge, the rest during SPLIT.
    emit      = take_word || (state == SPLIT && !last_byte);
    emit_byte = take_word ? bus.in_data[WORD_W-1 -: 8] : word[WORD_W-1 -: 8];
    {addr_carry, addr_inc} = {1'b0, addr} + (ADDR_W + 1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_mask    <= '0;
      addr       <= '0;
      words_left <= '0;
      word       <= '0;
      byte_idx   <= '0;
      wrapped    <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_run    <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we <= '0;
      if (take_start) begin
        we_mask    <= (int'(bus.sel) < NUM_MEM) ? (NUM_MEM'(1) << bus.sel) : '0;
        addr       <= bus.base_addr;
        words_left <= bus.word_count;
        wrapped    <= 1'b0;
        cpu_run    <= 1'b0;
        err        <= (int'(bus.sel) >= NUM_MEM);
      end
      if (take_word) begin
        word       <= bus.in_data << 8;
        byte_idx   <= '0;
        words_left <= words_left - ADDR_W'(1);
      end else if (emit) begin
        word       <= word << 8;
        byte_idx   <= byte_idx + BCNT_W'(1);
      end
      if (emit) begin
        mem_we    <= we_mask;
        mem_addr  <= addr;
        mem_wdata <= emit_byte;
        addr      <= addr_inc;
        wrapped   <= wrapped | addr_carry;
        // A write issued after the counter carried lands on a wrapped address.
        if (wrapped) err <= 1'b1;
      end
      if (state_next == FIN && state != FIN) cpu_run <= 1'b1;
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          bus.checksum <= '0;
    else if (take_start) bus.checksum <= '0;
    else if (take_word)  bus.checksum <= bus.checksum + bus.in_data;
  end
`else
  // Checksum disabled: no accumulator and no checksum signal on the interface.
`endif

  assign bus.in_ready  = (state == WAIT) && (words_left != '0);
  assign bus.busy      = (state == WAIT) || (state == SPLIT);
  assign bus.done      = (state == FIN);
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.cpu_run   = cpu_run;
  assign bus.err       = err;
endmodule

// File: tb/tb_mips_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_mips_boot_loader
//   Self-checking bench for mips_boot_loader. A reference model expands each
//   session's words into the expected byte-write list and expected status;
//   a monitor compares every memory write against that list.
// ---------------------------------------------------------------------------
module tb_mips_boot_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_boot_loader_if #(.WORD_W(32), .ADDR_W(16), .NUM_MEM(2)) bus ();

  mips_boot_loader #(.WORD_W(32), .ADDR_W(16), .NUM_MEM(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  we;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Every byte write must match the next expected write, in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_we !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.mem_we, bus.mem_addr}, 18'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_we",   bus.mem_we,    e.we);
        check("wr_addr", bus.mem_addr,  e.addr);
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Runs one session of words[] (at least one word) and checks its outcome.
  task automatic run_session(input logic s, input logic [15:0] base,
                             input int gap_lo, input int gap_hi, input bit poke_start);
    int          n;
    int          to;
    bit          exp_err;
    logic [31:0] sum;
    n   = words.size();
    sum = 32'h0;
    for (int i = 0; i < n; i++) begin
      sum += words[i];
      for (int k = 0; k < 4; k++) begin
        wr_t e;
        e.we   = 2'b01 << s;
        e.addr = 16'(int'(base) + i * 4 + k);
        e.data = words[i][31 - 8 * k -: 8];
        exp_q.push_back(e);
      end
    end
    exp_err = (int'(base) + n * 4 - 1) > 65535;

    @(negedge clk);
    bus.start = 1'b1; bus.sel = s; bus.base_addr = base; bus.word_count = 16'(n);
    @(negedge clk);
    bus.start = 1'b0; bus.sel = 1'($urandom); bus.base_addr = 16'($urandom);
    bus.word_count = 16'($urandom);
    check("busy_after_start", bus.busy, 1'b1);
    check("cpu_run_held", bus.cpu_run, 1'b0);
    check("err_cleared", bus.err, 1'b0);

    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = words[i];
      to = 0;
      while (!bus.in_ready && to < 50) begin
        @(negedge clk);
        to++;
      end
      check("ready_timeout", 32'(to < 50), 32'd1);
      @(negedge clk);                       // first byte cycle
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      check("ready_low_split", bus.in_ready, 1'b0);
      check("we_first_byte", bus.mem_we, 2'b01 << s);
      if (poke_start) begin
        bus.start = 1'b1; bus.sel = ~s; bus.base_addr = 16'h1234; bus.word_count = 16'd7;
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);            // last byte cycle
      check("ready_last_byte", bus.in_ready, 1'b0);
      @(negedge clk);
      if (i < n - 1) check("ready_again", bus.in_ready, 1'b1);
    end

    check("done_pulse", bus.done, 1'b1);
    check("cpu_run_at_done", bus.cpu_run, 1'b1);
    check("busy_at_done", bus.busy, 1'b0);
    check("err_at_done", bus.err, exp_err);
    check("writes_left", 32'(exp_q.size()), 32'd0);
`ifdef BOOT_LOADER_CHECKSUM_EN
    check("checksum_at_done", bus.checksum, sum);
`endif
    @(negedge clk);
    check("done_one_cycle", bus.done, 1'b0);
    check("cpu_run_stays", bus.cpu_run, 1'b1);
    check("err_sticky", bus.err, exp_err);
`ifdef BOOT_LOADER_CHECKSUM_EN
    check("checksum_stable", bus.checksum, sum);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sel = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_mem_we", bus.mem_we, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_cpu_run", bus.cpu_run, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_mem_wdata", bus.mem_wdata, 8'h0);
    rst_n = 1'b1;

    // Stream activity with no session is ignored.
    bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;

    // Instruction memory, two words.
    words = '{32'h0C000005, 32'h20090000};
    run_session(1'b0, 16'h0000, 0, 0, 1'b0);

    // Data memory, one word at offset 4.
    words = '{32'h00000028};
    run_session(1'b1, 16'h0004, 0, 0, 1'b0);

    // Empty session: done two cycles after the start cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.sel = 1'b0; bus.base_addr = 16'h0020; bus.word_count = 16'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("empty_busy", bus.busy, 1'b1);
    check("empty_no_done_yet", bus.done, 1'b0);
    check("empty_cpu_run_low", bus.cpu_run, 1'b0);
    @(negedge clk);
    check("empty_done", bus.done, 1'b1);
    check("empty_cpu_run", bus.cpu_run, 1'b1);
    check("empty_err", bus.err, 1'b0);
    @(negedge clk);
    check("empty_done_once", bus.done, 1'b0);

    // Address wrap at the top of memory.
    words = '{$urandom, $urandom};
    run_session(1'b0, 16'hFFFC, 0, 0, 1'b0);

    // Gapped stream with a stray start during SPLIT.
    words = '{$urandom, $urandom, $urandom};
    run_session(1'b1, 16'h0100, 3, 3, 1'b1);

    // Checksum wraps modulo 2^32.
    words = '{32'hFFFFFFFF, 32'h00000002};
    run_session(1'b0, 16'h0040, 0, 1, 1'b0);

    // Reset in the middle of SPLIT aborts the session at once.
    begin
      wr_t e;
      words = '{32'hA1B2C3D4};
      for (int k = 0; k < 4; k++) begin
        e.we = 2'b01; e.addr = 16'(16'h0200 + k); e.data = words[0][31 - 8 * k -: 8];
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    bus.start = 1'b1; bus.sel = 1'b0; bus.base_addr = 16'h0200; bus.word_count = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = words[0];
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_we", bus.mem_we, 2'b00);
    check("midrst_cpu_run", bus.cpu_run, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("postrst_idle_busy", bus.busy, 1'b0);
      check("postrst_idle_ready", bus.in_ready, 1'b0);
    end

    // Randomized sessions.
    for (int r = 0; r < 10; r++) begin
      logic [15:0] base;
      int          n;
      n = $urandom_range(4, 1);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      if ($urandom_range(2, 0) == 0) base = 16'hFFF0 + 16'($urandom_range(15, 0));
      else                           base = 16'($urandom);
      run_session(1'($urandom), base, 0, 4, 1'($urandom));
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
